// File: rtl/cpu_icache_pkg.sv
// Shared FSM state codes and address-field width helpers for the associative I-cache.
package cpu_icache_pkg;

   localparam logic [2:0] ST_INIT   = 3'd0;
   localparam logic [2:0] ST_IDLE   = 3'd1;
   localparam logic [2:0] ST_LOOKUP = 3'd2;
   localparam logic [2:0] ST_FILL   = 3'd3;
   localparam logic [2:0] ST_FLUSH  = 3'd4;

   // Address layout: | tag | set index | word offset | 2'b00 |
   function automatic int tag_width(input int sets_log2, input int line_words_log2);
      return 30 - sets_log2 - line_words_log2;
   endfunction

   function automatic int index_lsb(input int line_words_log2);
      return line_words_log2 + 2;
   endfunction

   function automatic int tag_lsb(input int sets_log2, input int line_words_log2);
      return sets_log2 + line_words_log2 + 2;
   endfunction

endpackage

// File: rtl/cpu_icache_way.sv
// One cache way: tag and whole-line data arrays, single write port, registered read.
module cpu_icache_way
   import cpu_icache_pkg::*;
#(
   parameter int SETS_LOG2 = 6,
   parameter int TAG_W     = tag_width(6, 2),
   parameter int LINE_W    = 128
) (
   input  logic                 i_clock,
   input  logic [SETS_LOG2-1:0] rd_index,
   output logic [TAG_W-1:0]     rd_tag,
   output logic [LINE_W-1:0]    rd_line,
   input  logic                 wr_en,
   input  logic [SETS_LOG2-1:0] wr_index,
   input  logic [TAG_W-1:0]     wr_tag,
   input  logic [LINE_W-1:0]    wr_line
);

   logic [TAG_W-1:0]  tag_mem  [2**SETS_LOG2];
   logic [LINE_W-1:0] data_mem [2**SETS_LOG2];

   always_ff @(posedge i_clock) begin
      if (wr_en) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_line;
      end
      rd_tag  <= tag_mem[rd_index];
      rd_line <= data_mem[rd_index];
   end

endmodule

// File: rtl/cpu_icache_assoc.sv
// Set-associative instruction cache with round-robin replacement and a single-word refill bus.
// Optional hit/miss counters are built when ICACHE_PERF_COUNTERS_EN is defined.
module cpu_icache_assoc
   import cpu_icache_pkg::*;
#(
   parameter int WAYS            = 2,
   parameter int SETS_LOG2       = 6,
   parameter int LINE_WORDS_LOG2 = 2
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic [31:0] i_input_pc,
   input  logic        i_stall,
   input  logic        i_flush,
   output logic [31:0] o_rdata,
   output logic        o_ready,
   output logic        o_busy,
   output logic        o_bus_request,
   input  logic        i_bus_ready,
   output logic [31:0] o_bus_address,
   input  logic [31:0] i_bus_rdata
`ifdef ICACHE_PERF_COUNTERS_EN
   ,
   output logic [31:0] o_hit_count,
   output logic [31:0] o_miss_count
`endif
);

   localparam int SETS       = 1 << SETS_LOG2;
   localparam int LINE_WORDS = 1 << LINE_WORDS_LOG2;
   localparam int LINE_W     = 32 * LINE_WORDS;
   localparam int TAG_W      = tag_width(SETS_LOG2, LINE_WORDS_LOG2);
   localparam int IDX_LSB    = index_lsb(LINE_WORDS_LOG2);
   localparam int TAG_LSB    = tag_lsb(SETS_LOG2, LINE_WORDS_LOG2);
   localparam int RR_W       = (WAYS > 1) ? $clog2(WAYS) : 1;

   logic [2:0]                 state_reg, state_next;
   logic [SETS_LOG2-1:0]       clr_cnt_reg;
   logic [LINE_WORDS_LOG2-1:0] word_cnt_reg;
   logic                       flush_pend_reg;
   logic [31:2]                pc_reg;
   logic [RR_W-1:0]            victim_reg, victim_next;
   logic [RR_W-1:0]            rr_reg [SETS];
   logic [WAYS-1:0]            valid_reg [SETS];
   logic [31:0]                line_buf_reg [LINE_WORDS];

   logic [TAG_W-1:0]  way_tag  [WAYS];
   logic [LINE_W-1:0] way_line [WAYS];
   logic [WAYS-1:0]   way_wr;

   logic [SETS_LOG2-1:0]       rd_index;
   logic [SETS_LOG2-1:0]       pc_index;
   logic [TAG_W-1:0]           pc_tag;
   logic [LINE_WORDS_LOG2-1:0] pc_offset;
   logic                       unused_pc_bits;

   logic              hit_any;
   logic [LINE_W-1:0] hit_line;
   logic [31:0]       hit_words [LINE_WORDS];
   logic [LINE_W-1:0] fill_line;
   logic [31:0]       fill_word;
   logic              lookup_hit, lookup_miss, fill_last, accept;

   // The RAM read is issued from the live PC in IDLE; everything later uses the captured copy.
   assign rd_index       = i_input_pc[TAG_LSB-1:IDX_LSB];
   assign pc_index       = pc_reg[TAG_LSB-1:IDX_LSB];
   assign pc_tag         = pc_reg[31:TAG_LSB];
   assign pc_offset      = pc_reg[IDX_LSB-1:2];
   assign unused_pc_bits = ^i_input_pc[1:0];

   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_way
         assign way_wr[gi] = fill_last && (victim_reg == RR_W'(gi));
         cpu_icache_way #(
            .SETS_LOG2 (SETS_LOG2),
            .TAG_W     (TAG_W),
            .LINE_W    (LINE_W)
         ) u_way (
            .i_clock  (i_clock),
            .rd_index (rd_index),
            .rd_tag   (way_tag[gi]),
            .rd_line  (way_line[gi]),
            .wr_en    (way_wr[gi]),
            .wr_index (pc_index),
            .wr_tag   (pc_tag),
            .wr_line  (fill_line)
         );
      end

      // The last beat is written straight from the bus, so the buffer only holds the earlier words.
      for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
         assign hit_words[gi]            = hit_line[gi*32 +: 32];
         assign fill_line[gi*32 +: 32]   = (gi == LINE_WORDS - 1) ? i_bus_rdata : line_buf_reg[gi];
      end
   endgenerate

   always_comb begin
      hit_any  = 1'b0;
      hit_line = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_reg[pc_index][w] && (way_tag[w] == pc_tag)) begin
            hit_any  = 1'b1;
            hit_line = way_line[w];
         end
      end
   end

   // Lowest invalid way wins; the round-robin pointer is only consulted when the set is full.
   always_comb begin
      victim_next = rr_reg[pc_index];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_reg[pc_index][w]) begin
            victim_next = RR_W'(w);
         end
      end
   end

   assign accept      = (state_reg == ST_IDLE) && !i_flush && !flush_pend_reg && !i_stall;
   assign lookup_hit  = (state_reg == ST_LOOKUP) && hit_any;
   assign lookup_miss = (state_reg == ST_LOOKUP) && !hit_any;
   assign fill_last   = (state_reg == ST_FILL) && i_bus_ready && (word_cnt_reg == '1);
   assign fill_word   = (pc_offset == '1) ? i_bus_rdata : line_buf_reg[pc_offset];

   assign o_ready       = lookup_hit || fill_last;
   assign o_rdata       = lookup_hit ? hit_words[pc_offset] : (fill_last ? fill_word : 32'd0);
   assign o_busy        = (state_reg == ST_INIT) || (state_reg == ST_FLUSH);
   assign o_bus_request = (state_reg == ST_FILL);
   assign o_bus_address = {pc_reg[31:IDX_LSB], word_cnt_reg, 2'b00};

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_INIT, ST_FLUSH: if (clr_cnt_reg == '1) state_next = ST_IDLE;
         ST_IDLE: begin
            if (i_flush || flush_pend_reg) state_next = ST_FLUSH;
            else if (!i_stall)             state_next = ST_LOOKUP;
         end
         ST_LOOKUP: state_next = hit_any ? ST_IDLE : ST_FILL;
         ST_FILL:   if (fill_last) state_next = ST_IDLE;
         default:   state_next = ST_INIT;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_reg      <= ST_INIT;
         clr_cnt_reg    <= '0;
         word_cnt_reg   <= '0;
         flush_pend_reg <= 1'b0;
         pc_reg         <= '0;
         victim_reg     <= '0;
         for (int s = 0; s < SETS; s++) rr_reg[s] <= '0;
      end else begin
         state_reg <= state_next;

         if ((state_reg == ST_INIT) || (state_reg == ST_FLUSH)) clr_cnt_reg <= clr_cnt_reg + 1'b1;
         else                                                   clr_cnt_reg <= '0;

         // Any flush seen in IDLE is taken immediately, so only requests elsewhere need remembering.
         if (state_reg == ST_IDLE) flush_pend_reg <= 1'b0;
         else if (i_flush)         flush_pend_reg <= 1'b1;

         if (accept) pc_reg <= i_input_pc[31:2];

         if (lookup_miss) begin
            victim_reg <= victim_next;
            if (&valid_reg[pc_index]) begin
               rr_reg[pc_index] <= (rr_reg[pc_index] == RR_W'(WAYS - 1)) ? '0 : rr_reg[pc_index] + 1'b1;
            end
         end

         if ((state_reg == ST_FILL) && i_bus_ready) word_cnt_reg <= word_cnt_reg + 1'b1;
      end
   end

   // Valid bits and the fill buffer need no reset: INIT sweeps every set before any lookup.
   always_ff @(posedge i_clock) begin
      if ((state_reg == ST_INIT) || (state_reg == ST_FLUSH)) begin
         valid_reg[clr_cnt_reg] <= '0;
      end else if (fill_last) begin
         valid_reg[pc_index][victim_reg] <= 1'b1;
      end
      if ((state_reg == ST_FILL) && i_bus_ready) begin
         line_buf_reg[word_cnt_reg] <= i_bus_rdata;
      end
   end

`ifdef ICACHE_PERF_COUNTERS_EN
   logic [31:0] hit_count_reg, miss_count_reg;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         hit_count_reg  <= '0;
         miss_count_reg <= '0;
      end else begin
         if (lookup_hit)  hit_count_reg  <= hit_count_reg + 32'd1;
         if (lookup_miss) miss_count_reg <= miss_count_reg + 32'd1;
      end
   end

   assign o_hit_count  = hit_count_reg;
   assign o_miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_cpu_icache_assoc.sv
// Randomized bench for cpu_icache_assoc against a set/way/round-robin reference model.
module tb_cpu_icache_assoc;

   localparam int WAYS = 2;
   localparam int SETS = 64;

   logic        clk = 1'b0;
   logic        i_reset, i_stall, i_flush, i_bus_ready;
   logic [31:0] i_input_pc, i_bus_rdata;
   logic [31:0] o_rdata, o_bus_address;
   logic        o_ready, o_busy, o_bus_request;
`ifdef ICACHE_PERF_COUNTERS_EN
   logic [31:0] o_hit_count, o_miss_count;
`endif

   always #5 clk = ~clk;

   cpu_icache_assoc #(.WAYS(2), .SETS_LOG2(6), .LINE_WORDS_LOG2(2)) dut (
      .i_clock       (clk),
      .i_reset       (i_reset),
      .i_input_pc    (i_input_pc),
      .i_stall       (i_stall),
      .i_flush       (i_flush),
      .o_rdata       (o_rdata),
      .o_ready       (o_ready),
      .o_busy        (o_busy),
      .o_bus_request (o_bus_request),
      .i_bus_ready   (i_bus_ready),
      .o_bus_address (o_bus_address),
      .i_bus_rdata   (i_bus_rdata)
`ifdef ICACHE_PERF_COUNTERS_EN
      ,
      .o_hit_count   (o_hit_count),
      .o_miss_count  (o_miss_count)
`endif
   );

   int checks = 0, failures = 0;
   bit bus_rand = 1'b1;
   logic [31:0] bus_log [$];
   int busreq_cycles = 0, dbl_ready = 0, rdata_bad = 0, req_while_busy = 0;
   bit prev_ready = 1'b0;

   // Reference model: which line tags live in each set, and the per-set replacement pointer.
   bit          m_valid [SETS][WAYS];
   logic [21:0] m_tag   [SETS][WAYS];
   int          m_rr    [SETS];
   int          m_hits = 0, m_misses = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic model_clear(input bit clear_rr);
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
         if (clear_rr) m_rr[s] = 0;
      end
   endtask

   task automatic model_fetch(input logic [31:0] pc, output bit hit);
      int s, v;
      logic [21:0] t;
      s = int'(pc[9:4]);
      t = pc[31:10];
      hit = 1'b0;
      for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) hit = 1'b1;
      if (hit) begin
         m_hits++;
      end else begin
         m_misses++;
         v = -1;
         for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
         if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % WAYS;
         end
         m_valid[s][v] = 1'b1;
         m_tag[s][v] = t;
      end
   endtask

   // One clock: respond on the bus at the falling edge, then observe settled outputs.
   task automatic step();
      @(negedge clk);
      i_bus_ready = o_bus_request && (!bus_rand || ($urandom_range(0, 3) != 0));
      i_bus_rdata = mem_word(o_bus_address);
      #1;
      if (o_bus_request) begin
         busreq_cycles++;
         if (o_busy) req_while_busy++;
         if (i_bus_ready) bus_log.push_back(o_bus_address);
      end
      if (o_ready && prev_ready) dbl_ready++;
      if (!o_ready && o_rdata != 32'd0) rdata_bad++;
      prev_ready = o_ready;
   endtask

   task automatic wait_idle();
      int g = 0;
      step();
      while (o_busy && g < 500) begin
         step();
         g++;
      end
   endtask

   task automatic fetch(input logic [31:0] pc, output bit ok, output int lat,
                        output logic [31:0] data, output int nbus);
      wait_idle();
      bus_log.delete();
      i_input_pc = pc;
      i_stall = 1'b0;
      ok = 1'b0;
      lat = 0;
      data = 32'd0;
      while (!ok && lat < 300) begin
         step();
         lat++;
         if (o_ready) begin
            ok = 1'b1;
            data = o_rdata;
         end
      end
      i_stall = 1'b1;
      nbus = bus_log.size();
   endtask

   // Full check of one fetch against the model: completion, data, hit latency, refill sequence.
   task automatic test_fetch_one(input logic [31:0] pc, input string tag_name);
      bit ok, hit;
      int lat, nbus;
      logic [31:0] d, base;
      model_fetch(pc, hit);
      fetch(pc, ok, lat, d, nbus);
      base = {pc[31:4], 4'h0};
      checks++;
      if (!ok) begin failures++; $display("FAIL %s_timeout pc=%h got no o_ready want o_ready", tag_name, pc); end
      checks++;
      if (d !== mem_word(pc)) begin failures++; $display("FAIL %s_data pc=%h got %h want %h", tag_name, pc, d, mem_word(pc)); end
      checks++;
      if (nbus !== (hit ? 0 : 4)) begin failures++; $display("FAIL %s_buswords pc=%h got %0d want %0d", tag_name, pc, nbus, hit ? 0 : 4); end
      if (hit) begin
         checks++;
         if (lat !== 1) begin failures++; $display("FAIL %s_hit_latency pc=%h got %0d want 1", tag_name, pc, lat); end
      end else if (nbus == 4) begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus_log[k] !== base + 32'(4 * k)) begin
               failures++;
               $display("FAIL %s_busaddr%0d pc=%h got %h want %h", tag_name, k, pc, bus_log[k], base + 32'(4 * k));
            end
         end
      end
      $display("fetch %-8s pc=%h hit=%0d lat=%0d data=%h", tag_name, pc, hit, lat, d);
   endtask

   task automatic test_reset();
      int cnt = 0, g = 0;
      repeat (3) step();
      checks++;
      if ({o_busy, o_ready, o_bus_request} !== 3'b100 || o_rdata !== 32'd0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%b ready=%b req=%b rdata=%h want 1 0 0 0", o_busy, o_ready, o_bus_request, o_rdata);
      end
      @(posedge clk);
      #1 i_reset = 1'b1;
      busreq_cycles = 0;
      step();
      while (o_busy && g < 200) begin
         cnt++;
         step();
         g++;
      end
      if (!o_busy) cnt++;
      cnt--;
      checks++;
      if (cnt !== 64) begin failures++; $display("FAIL init_busy_cycles got %0d want 64", cnt); end
      checks++;
      if (busreq_cycles !== 0) begin failures++; $display("FAIL init_bus_request got %0d cycles want 0", busreq_cycles); end
      $display("reset init busy cycles=%0d", cnt);
   endtask

   task automatic test_evict();
      test_fetch_one(32'h500, "evict_a");
      test_fetch_one(32'h900, "evict_b");
      checks++;
      if (m_tag[16][0] !== 22'h2) begin failures++; $display("FAIL evict_model_way0 got %h want 2", m_tag[16][0]); end
      test_fetch_one(32'h100, "evict_re");
      test_fetch_one(32'h900, "evict_hit");
   endtask

   task automatic test_flush_during_fill();
      bit got = 1'b0, seen_req = 1'b0, seen = 1'b0, hit;
      int g = 0, bc = 0;
      logic [31:0] d = 32'd0;
      wait_idle();
      bus_log.delete();
      i_input_pc = 32'h200;
      i_stall = 1'b0;
      while (!got && g < 300) begin
         step();
         g++;
         if (o_ready) begin
            got = 1'b1;
            d = o_rdata;
         end else if (o_bus_request && !seen_req) begin
            seen_req = 1'b1;
            i_flush = 1'b1;
            step();
            g++;
            i_flush = 1'b0;
            if (o_ready) begin
               got = 1'b1;
               d = o_rdata;
            end
         end
      end
      i_stall = 1'b1;
      model_fetch(32'h200, hit);
      checks++;
      if (!got || d !== mem_word(32'h200)) begin
         failures++;
         $display("FAIL flush_fill_complete got ready=%b data=%h want 1 %h", got, d, mem_word(32'h200));
      end
      g = 0;
      while (g < 200) begin
         step();
         g++;
         if (o_busy) begin
            bc++;
            seen = 1'b1;
         end else if (seen) begin
            break;
         end
      end
      checks++;
      if (bc !== 64) begin failures++; $display("FAIL flush_busy_cycles got %0d want 64", bc); end
      $display("flush during fill data=%h busy cycles=%0d", d, bc);
      model_clear(1'b0);
      test_fetch_one(32'h100, "postflsh");
   endtask

   task automatic test_stall();
      int req0, rdy = 0;
      wait_idle();
      i_input_pc = 32'h104;
      i_stall = 1'b1;
      req0 = busreq_cycles;
      repeat (10) begin
         step();
         if (o_ready) rdy++;
      end
      checks++;
      if (rdy !== 0 || busreq_cycles !== req0) begin
         failures++;
         $display("FAIL stall_hold got ready=%0d req=%0d want 0 0", rdy, busreq_cycles - req0);
      end
      $display("stall 10 cycles ready=%0d", rdy);
      test_fetch_one(32'h104, "unstall");
   endtask

   task automatic test_random();
      logic [31:0] pc;
      int sets[3] = '{16, 3, 40};
      for (int n = 0; n < 60; n++) begin
         pc = (32'($urandom_range(0, 4)) << 10) | (32'(sets[$urandom_range(0, 2)]) << 4)
              | (32'($urandom_range(0, 3)) << 2);
         test_fetch_one(pc, "random");
      end
   endtask

   task automatic test_reset_midfill();
      int g = 0;
      wait_idle();
      bus_rand = 1'b0;
      bus_log.delete();
      i_input_pc = 32'hABC0;
      i_stall = 1'b0;
      while (bus_log.size() < 2 && g < 100) begin
         step();
         g++;
      end
      @(posedge clk);
      #2 i_reset = 1'b0;
      #1;
      checks++;
      if ({o_bus_request, o_ready, o_busy} !== 3'b001 || o_rdata !== 32'd0) begin
         failures++;
         $display("FAIL midfill_reset got req=%b ready=%b busy=%b rdata=%h want 0 0 1 0", o_bus_request, o_ready, o_busy, o_rdata);
      end
      i_stall = 1'b1;
      bus_rand = 1'b1;
      repeat (3) step();
      @(posedge clk);
      #1 i_reset = 1'b1;
      model_clear(1'b1);
      m_hits = 0;
      m_misses = 0;
      wait_idle();
`ifdef ICACHE_PERF_COUNTERS_EN
      checks++;
      if (o_hit_count !== 32'd0 || o_miss_count !== 32'd0) begin
         failures++;
         $display("FAIL counters_after_reset got %0d %0d want 0 0", o_hit_count, o_miss_count);
      end
`endif
      $display("reset mid-fill after %0d words", bus_log.size());
      test_fetch_one(32'h100, "postrst");
   endtask

   task automatic test_invariants();
      checks++;
      if (dbl_ready !== 0) begin failures++; $display("FAIL ready_back_to_back got %0d want 0", dbl_ready); end
      checks++;
      if (rdata_bad !== 0) begin failures++; $display("FAIL rdata_without_ready got %0d want 0", rdata_bad); end
      checks++;
      if (req_while_busy !== 0) begin failures++; $display("FAIL request_while_busy got %0d want 0", req_while_busy); end
`ifdef ICACHE_PERF_COUNTERS_EN
      checks++;
      if (o_hit_count !== 32'(m_hits) || o_miss_count !== 32'(m_misses)) begin
         failures++;
         $display("FAIL perf_counters got %0d/%0d want %0d/%0d", o_hit_count, o_miss_count, m_hits, m_misses);
      end
`endif
      $display("invariants dbl_ready=%0d rdata_bad=%0d", dbl_ready, rdata_bad);
   endtask

   initial begin
      i_reset = 1'b0;
      i_stall = 1'b1;
      i_flush = 1'b0;
      i_input_pc = 32'd0;
      i_bus_ready = 1'b0;
      i_bus_rdata = 32'd0;
      model_clear(1'b1);
      test_reset();
      test_fetch_one(32'h100, "fill");
      test_fetch_one(32'h108, "hit");
      test_evict();
      test_flush_during_fill();
      test_stall();
      test_random();
      test_reset_midfill();
      test_invariants();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
